tdm_demux4: RTL and testbench
=============================

Name: tdm_demux4

Overview:
- Receive end of the 4-channel time-division link whose transmit end is the 4:1 nibble mux.
- Accepts one serialized WIDTH-bit word per beat, with a start-of-frame marker on slot 0.
- Reassembles each frame of four beats into four parallel channel registers (a, b, c, d).
- Presents the assembled frame through a valid/ready output handshake, and flags framing errors and dropped frames.

Parameters:
- WIDTH, 4, width of each channel word and of the serial data bus.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- en  input  1  receive enable, active-high; when 0 no input beat is accepted.
- in_valid  input  1  in_data/in_sof carry a beat this cycle.
- in_sof  input  1  beat is slot 0 (channel a) of a new frame.
- in_data  input  WIDTH  serialized channel word.
- out_a  output  WIDTH  channel a (slot 0) of the presented frame.
- out_b  output  WIDTH  channel b (slot 1).
- out_c  output  WIDTH  channel c (slot 2).
- out_d  output  WIDTH  channel d (slot 3).
- out_valid  output  1  out_a..out_d hold a complete, unconsumed frame.
- out_ready  input  1  consumer accepts the frame when out_valid && out_ready.
- frame_err  output  1  one-cycle pulse: in_sof seen mid-frame.
- overflow  output  1  one-cycle pulse: completed frame dropped because output busy.
- busy  output  1  1 while a frame is partially collected (state COLLECT).

Behaviour:
- Reset (reset_n==0 at clk edge): state IDLE, slot counter 0, shadow regs 0, out_a..out_d 0, out_valid 0, frame_err 0, overflow 0, busy 0. Reset has priority over every other event, including a beat on the same edge; a partial frame is discarded.
- Accepted beat = en && in_valid. en==0 freezes the slot counter and state; output handshake still operates.
- States: IDLE, COLLECT.
- IDLE:
  - accepted beat with in_sof=1 -> shadow[0]=in_data, cnt=1, go COLLECT.
  - accepted beat with in_sof=0 -> ignored, no flag.
- COLLECT:
  - accepted beat with in_sof=0 -> shadow[cnt]=in_data, cnt=cnt+1.
  - accepted beat with in_sof=1 -> frame_err=1 next cycle; partial frame discarded; beat taken as new slot 0 (shadow[0]=in_data, cnt=1); stay COLLECT.
  - beat into slot 3 completes the frame: cnt wraps to 0, go IDLE.
- Completion: on the edge capturing slot 3, the frame transfers to out_a..out_d from shadow[0..2] and the live in_data for slot 3.
  - If out_valid==0 or out_ready==1 that cycle: outputs load and out_valid=1.
  - Otherwise: outputs unchanged, out_valid stays 1, overflow=1 next cycle, and the new frame is lost.
- Latency: out_valid rises the cycle after the fourth beat is accepted.
- Handshake:
  - out_valid && out_ready && no completion -> out_valid=0; outputs hold their last values.
  - out_valid && out_ready together with a completion -> new frame loads and out_valid stays 1 (back-to-back, no bubble).
  - out_a..out_d are stable while out_valid=1 and out_ready=0.
- frame_err and overflow are registered single-cycle pulses. Both can assert in the same cycle only if the triggering events coincide.
- busy = (state==COLLECT).

Test Plan:
- Basic frame, out_ready=1: en=1; beats 4(sof),0,1,D on consecutive cycles -> one cycle after beat D: out_a..d=4,0,1,D, out_valid=1, busy back to 0. out_valid drops the next cycle.
- Backpressure/overflow: frame 4,0,1,D then frame 8,D,F,0 with out_ready=0 -> outputs stay 4,0,1,D, overflow pulses once after beat 0. Then out_ready=1 -> out_valid=0.
- Back-to-back: frames 0,4,4,B and 9,C,D,2 with out_ready asserted on the completion edge of the second -> outputs switch to 9,C,D,2 with out_valid held at 1.
- Framing error: beats 8(sof),D, then 9(sof),C,D,2 -> frame_err pulses once, output frame = 9,C,D,2, no overflow.
- Enable gating and stray data: beats 5,6 without sof in IDLE are ignored. en=0 for 3 cycles mid-frame (in_valid=1, junk data) does not advance slots. Frame 4,0,1,D split around the gap still assembles to 4,0,1,D.
- Reset mid-frame: beats 4(sof),0, then reset_n=0 for 1 cycle, then 1,D without sof -> no out_valid. All outputs 0 after reset.

Source files
------------

// File: rtl/tdm_demux4.sv
// Receive end of the 4-channel TDM link: reassembles four serial beats per frame
// into parallel channel registers presented through a valid/ready handshake.
module tdm_demux4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t           state, state_next;
    logic [1:0]       cnt, cnt_next;
    logic [WIDTH-1:0] shadow [3];

    logic       accept;
    logic       shadow_we;
    logic [1:0] shadow_idx;
    logic       complete;
    logic       load;
    logic       err_next;
    logic       ovf_next;
    logic       valid_next;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        accept     = en && in_valid;
        state_next = state;
        cnt_next   = cnt;
        shadow_we  = 1'b0;
        shadow_idx = 2'd0;
        complete   = 1'b0;
        err_next   = 1'b0;

        case (state)
            IDLE: begin
                if (accept && in_sof) begin
                    shadow_we  = 1'b1;
                    cnt_next   = 2'd1;
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (in_sof) begin
                        // Resynchronise on the new marker; the partial frame is abandoned.
                        err_next  = 1'b1;
                        shadow_we = 1'b1;
                        cnt_next  = 2'd1;
                    end else if (cnt == 2'd3) begin
                        complete   = 1'b1;
                        cnt_next   = 2'd0;
                        state_next = IDLE;
                    end else begin
                        shadow_we  = 1'b1;
                        shadow_idx = cnt;
                        cnt_next   = cnt + 2'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 2'd0;
            end
        endcase

        // A completed frame may only replace the presented one if that one is free or leaving now.
        load     = complete && (!out_valid || out_ready);
        ovf_next = complete && !load;

        if (load)
            valid_next = 1'b1;
        else if (out_ready)
            valid_next = 1'b0;
        else
            valid_next = out_valid;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: the three-entry shadow store is cleared on reset so a discarded frame never leaks out.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++)
                shadow[i] <= '0;
            out_a     <= '0;
            out_b     <= '0;
            out_c     <= '0;
            out_d     <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (shadow_we && shadow_idx == 2'(i))
                    shadow[i] <= in_data;
            // Slot 3 is taken straight from the bus on the completing edge.
            if (load) begin
                out_a <= shadow[0];
                out_b <= shadow[1];
                out_c <= shadow[2];
                out_d <= in_data;
            end
            out_valid <= valid_next;
            frame_err <= err_next;
            overflow  <= ovf_next;
        end
    end

    assign busy = (state == COLLECT);

endmodule

// File: tb/tb_tdm_demux4.sv
// Scoreboard bench for tdm_demux4: stimulus pushes expected frames, a negedge
// monitor pops and compares each frame as it is consumed.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       in_valid;
    logic       in_sof;
    logic [3:0] in_data;
    logic [3:0] out_a, out_b, out_c, out_d;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int err_seen = 0;
    int ovf_seen = 0;
    int err_base;
    int ovf_base;

    logic [15:0] exp_q [$];

    tdm_demux4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic push_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        exp_q.push_back({a, b, c, d});
    endtask

    task automatic beat(input logic sof, input logic [3:0] d);
        en       = 1'b1;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: a frame is consumed on the next rising edge whenever valid && ready here.
    always @(negedge clk) begin
        if (frame_err === 1'b1) err_seen++;
        if (overflow === 1'b1) ovf_seen++;
        if (reset_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame: got %h%h%h%h expected none", out_a, out_b, out_c, out_d);
            end else begin
                check("frame", {out_a, out_b, out_c, out_d}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        en        = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        in_data   = 4'h0;
        out_ready = 1'b0;
        idle(2);
        check("reset_outputs", {out_a, out_b, out_c, out_d}, 16'h0000);
        check("reset_flags", {12'h0, out_valid, frame_err, overflow, busy}, 16'h0);
        reset_n = 1'b1;
        idle(1);

        // Basic frame with the consumer always ready.
        out_ready = 1'b1;
        push_frame(4'h4, 4'h0, 4'h1, 4'hD);
        beat(1'b1, 4'h4);
        check("basic_busy_mid", {15'h0, busy}, 16'h1);
        beat(1'b0, 4'h0);
        beat(1'b0, 4'h1);
        beat(1'b0, 4'hD);
        check("basic_valid", {15'h0, out_valid}, 16'h1);
        check("basic_busy_done", {15'h0, busy}, 16'h0);
        idle(1);
        check("basic_valid_drop", {15'h0, out_valid}, 16'h0);

        // Backpressure: second frame is dropped and overflow pulses once.
        out_ready = 1'b0;
        ovf_base  = ovf_seen;
        push_frame(4'h4, 4'h0, 4'h1, 4'hD);
        beat(1'b1, 4'h4); beat(1'b0, 4'h0); beat(1'b0, 4'h1); beat(1'b0, 4'hD);
        beat(1'b1, 4'h8); beat(1'b0, 4'hD); beat(1'b0, 4'hF);
        check("ovf_quiet", {15'h0, overflow}, 16'h0);
        beat(1'b0, 4'h0);
        check("ovf_pulse", {15'h0, overflow}, 16'h1);
        check("ovf_hold", {out_a, out_b, out_c, out_d}, 16'h401D);
        idle(1);
        check("ovf_single", {15'h0, overflow}, 16'h0);
        out_ready = 1'b1;
        idle(1);
        check("ovf_release", {15'h0, out_valid}, 16'h0);
        check("ovf_count", 16'(ovf_seen - ovf_base), 16'd1);

        // Back-to-back: ready arrives on the completing edge of the second frame.
        out_ready = 1'b0;
        push_frame(4'h0, 4'h4, 4'h4, 4'hB);
        push_frame(4'h9, 4'hC, 4'hD, 4'h2);
        beat(1'b1, 4'h0); beat(1'b0, 4'h4); beat(1'b0, 4'h4); beat(1'b0, 4'hB);
        beat(1'b1, 4'h9); beat(1'b0, 4'hC); beat(1'b0, 4'hD);
        out_ready = 1'b1;
        beat(1'b0, 4'h2);
        check("b2b_valid", {15'h0, out_valid}, 16'h1);
        check("b2b_frame", {out_a, out_b, out_c, out_d}, 16'h9CD2);
        check("b2b_no_ovf", {15'h0, overflow}, 16'h0);
        idle(1);
        check("b2b_drain", {15'h0, out_valid}, 16'h0);

        // Framing error: sof arrives after two beats.
        err_base = err_seen;
        ovf_base = ovf_seen;
        push_frame(4'h9, 4'hC, 4'hD, 4'h2);
        beat(1'b1, 4'h8); beat(1'b0, 4'hD);
        beat(1'b1, 4'h9);
        check("ferr_pulse", {15'h0, frame_err}, 16'h1);
        beat(1'b0, 4'hC);
        check("ferr_single", {15'h0, frame_err}, 16'h0);
        beat(1'b0, 4'hD); beat(1'b0, 4'h2);
        idle(2);
        check("ferr_count", 16'(err_seen - err_base), 16'd1);
        check("ferr_no_ovf", 16'(ovf_seen - ovf_base), 16'd0);

        // Enable gating and stray data in IDLE.
        err_base = err_seen;
        beat(1'b0, 4'h5); beat(1'b0, 4'h6);
        check("stray_idle", {14'h0, busy, out_valid}, 16'h0);
        push_frame(4'h4, 4'h0, 4'h1, 4'hD);
        beat(1'b1, 4'h4); beat(1'b0, 4'h0);
        en       = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 4'hF;
        idle(3);
        check("gate_busy", {15'h0, busy}, 16'h1);
        check("gate_no_err", {15'h0, frame_err}, 16'h0);
        beat(1'b0, 4'h1); beat(1'b0, 4'hD);
        check("gate_valid", {15'h0, out_valid}, 16'h1);
        idle(2);
        check("gate_err_count", 16'(err_seen - err_base), 16'd0);

        // Reset mid-frame discards the partial frame and clears the outputs.
        beat(1'b1, 4'h4); beat(1'b0, 4'h0);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        check("rst_outputs", {out_a, out_b, out_c, out_d}, 16'h0000);
        check("rst_flags", {12'h0, out_valid, frame_err, overflow, busy}, 16'h0);
        beat(1'b0, 4'h1); beat(1'b0, 4'hD);
        check("rst_no_frame", {14'h0, busy, out_valid}, 16'h0);
        idle(4);

        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
